// File: rtl/tss_deserializer_rx_if.sv
// Byte-wide AXI-Stream carrying TSS timestamp-sync command frames, MSB first.
interface tss_deserializer_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tss_deserializer_rx.sv
// TSS receive deserializer: rebuilds COMMAND_WIDTH-bit commands from byte frames and drops malformed ones.
// Optional mid-frame idle timeout is built only when TSS_RX_TIMEOUT_EN is defined.
module tss_deserializer_rx #(
    parameter int COMMAND_WIDTH  = 128,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tss_deserializer_rx_if.slave     s_axis,
    output logic [COMMAND_WIDTH-1:0] command_o,
    output logic                     command_valid_o,
    output logic                     frame_err_o,
    output logic [1:0]               err_code_o,
    output logic [CNT_WIDTH-1:0]     frame_cnt_o,
    output logic [CNT_WIDTH-1:0]     err_cnt_o
);
    localparam int N     = COMMAND_WIDTH / 8;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {COLLECT, DROP, DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [COMMAND_WIDTH-1:0] shadow;
    logic                     beat;
    logic                     last_idx;
    logic                     good;
    logic                     err_nxt;
    logic [1:0]               code_nxt;
    logic                     timeout;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign s_axis.tready = (state != DONE);
    assign beat          = s_axis.tvalid && s_axis.tready;
    assign last_idx      = (idx == IDX_W'(N - 1));
    assign good          = (state == COLLECT) && beat && s_axis.tlast && last_idx;

`ifdef TSS_RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [GAP_W-1:0] gap;
    logic             gap_arm;

    // A beat in the would-be expiry cycle clears the count instead of timing out.
    assign gap_arm = ((state == COLLECT) && (idx != '0)) || (state == DROP);
    assign timeout = gap_arm && !beat && (gap == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || beat || !gap_arm || timeout) begin
            gap <= '0;
        end else begin
            gap <= gap + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = 1'b0;
        code_nxt  = err_code_o;
        unique case (state)
            COLLECT: begin
                if (timeout) begin
                    err_nxt  = 1'b1;
                    code_nxt = 2'b11;
                    idx_nxt  = '0;
                end else if (beat) begin
                    if (s_axis.tlast && last_idx) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else if (s_axis.tlast) begin
                        err_nxt  = 1'b1;
                        code_nxt = 2'b01;
                        idx_nxt  = '0;
                    end else if (last_idx) begin
                        state_nxt = DROP;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DROP: begin
                if (timeout) begin
                    err_nxt   = 1'b1;
                    code_nxt  = 2'b11;
                    state_nxt = COLLECT;
                end else if (beat && s_axis.tlast) begin
                    err_nxt   = 1'b1;
                    code_nxt  = 2'b10;
                    state_nxt = COLLECT;
                end
            end
            DONE: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= COLLECT;
            idx             <= '0;
            command_o       <= '0;
            command_valid_o <= 1'b0;
            frame_err_o     <= 1'b0;
            err_code_o      <= 2'b00;
            frame_cnt_o     <= '0;
            err_cnt_o       <= '0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            command_valid_o <= good;
            frame_err_o     <= err_nxt;
            err_code_o      <= code_nxt;
            // The word is published at the tlast beat so it is valid while DONE holds tready low.
            if (good) begin
                command_o   <= {shadow[COMMAND_WIDTH-9:0], s_axis.tdata};
                frame_cnt_o <= sat_inc(frame_cnt_o);
            end
            if (err_nxt) begin
                err_cnt_o <= sat_inc(err_cnt_o);
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == COLLECT) && beat) begin
            shadow <= {shadow[COMMAND_WIDTH-9:0], s_axis.tdata};
        end
    end
endmodule

// File: tb/tb_tss_deserializer_rx.sv
// Bench for tss_deserializer_rx: frame-level reference model compared every cycle, plus literal spot checks.
module tb_tss_deserializer_rx;
    localparam int N       = 16;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tss_deserializer_rx_if bus ();
    tss_deserializer_rx_if bus2 ();
    assign bus2.tdata  = bus.tdata;
    assign bus2.tvalid = bus.tvalid;
    assign bus2.tlast  = bus.tlast;

    logic [127:0] command, command2;
    logic         cv, cv2, ferr, ferr2;
    logic [1:0]   code, code2;
    logic [15:0]  fcnt, ecnt;
    logic [1:0]   fcnt2, ecnt2;

    tss_deserializer_rx #(.COMMAND_WIDTH(128), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(bus),
        .command_o(command), .command_valid_o(cv), .frame_err_o(ferr),
        .err_code_o(code), .frame_cnt_o(fcnt), .err_cnt_o(ecnt));

    // Narrow-counter instance on the same stream exposes saturation quickly.
    tss_deserializer_rx #(.COMMAND_WIDTH(128), .CNT_WIDTH(2), .TIMEOUT_CYCLES(TIMEOUT)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_axis(bus2),
        .command_o(command2), .command_valid_o(cv2), .frame_err_o(ferr2),
        .err_code_o(code2), .frame_cnt_o(fcnt2), .err_cnt_o(ecnt2));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frames as byte queues, counts kept unbounded and clipped on compare.
    logic [7:0]   mq[$];
    bit           m_drop, m_bubble, m_cv, m_err;
    logic [127:0] m_cmd;
    logic [1:0]   m_code;
    int unsigned  m_fraw, m_eraw;
    int           m_gap;

    function automatic int unsigned clip(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        m_cv  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_drop = 0; m_bubble = 0; m_cmd = '0; m_code = 2'b00;
            m_fraw = 0; m_eraw = 0; m_gap = 0;
        end else begin
            rdy      = !m_bubble;
            m_bubble = 1'b0;
            if (rdy && bus.tvalid) begin
                m_gap = 0;
                if (m_drop) begin
                    if (bus.tlast) begin
                        m_drop = 0; m_err = 1; m_code = 2'b10; m_eraw++;
                    end
                end else begin
                    mq.push_back(bus.tdata);
                    if (bus.tlast) begin
                        if (mq.size() == N) begin
                            for (int i = 0; i < N; i++) m_cmd[127-8*i -: 8] = mq[i];
                            m_cv = 1; m_fraw++; m_bubble = 1;
                        end else begin
                            m_err = 1; m_code = 2'b01; m_eraw++;
                        end
                        mq.delete();
                    end else if (mq.size() == N) begin
                        m_drop = 1;
                        mq.delete();
                    end
                end
            end
`ifdef TSS_RX_TIMEOUT_EN
            else if (mq.size() > 0 || m_drop) begin
                m_gap++;
                if (m_gap == TIMEOUT) begin
                    mq.delete(); m_drop = 0; m_gap = 0;
                    m_err = 1; m_code = 2'b11; m_eraw++;
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tready", {127'd0, bus.tready}, {127'd0, !m_bubble});
            check("command", command, m_cmd);
            check("cmd_valid", {127'd0, cv}, {127'd0, m_cv});
            check("frame_err", {127'd0, ferr}, {127'd0, m_err});
            check("err_code", {126'd0, code}, {126'd0, m_code});
            check("frame_cnt", {112'd0, fcnt}, 128'(clip(m_fraw, 65535)));
            check("err_cnt", {112'd0, ecnt}, 128'(clip(m_eraw, 65535)));
            check("tready2", {127'd0, bus2.tready}, {127'd0, !m_bubble});
            check("command2", command2, m_cmd);
            check("cmd_valid2", {127'd0, cv2}, {127'd0, m_cv});
            check("frame_err2", {127'd0, ferr2}, {127'd0, m_err});
            check("err_code2", {126'd0, code2}, {126'd0, m_code});
            check("frame_cnt2", {126'd0, fcnt2}, 128'(clip(m_fraw, 3)));
            check("err_cnt2", {126'd0, ecnt2}, 128'(clip(m_eraw, 3)));
        end
    end

    task automatic idle(input int n);
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit last, input int gap_pct);
        int guard;
        bus.tvalid = 1'b0;
        for (int k = 0; k < 6 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; k++) @(negedge clk);
        bus.tdata  = d;
        bus.tlast  = last;
        bus.tvalid = 1'b1;
        guard = 0;
        while (!bus.tready && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.tready) check("tready_wait", 128'd0, 128'd1);
        @(negedge clk);
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] start, input int len, input int gap_pct);
        for (int i = 0; i < len; i++) send(start + 8'(i), i == len - 1, gap_pct);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tdata  = 8'h00;
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_command", command, 128'd0);
        check("rst_cv", {127'd0, cv}, 128'd0);
        check("rst_err", {127'd0, ferr}, 128'd0);
        check("rst_code", {126'd0, code}, 128'd0);
        check("rst_fcnt", {112'd0, fcnt}, 128'd0);
        check("rst_ecnt", {112'd0, ecnt}, 128'd0);
        check("rst_tready", {127'd0, bus.tready}, 128'd1);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back good frame: strobe and bubble land right after the tlast beat.
        send_frame(8'h00, 16, 0);
        check("lit_cv_after_last", {127'd0, cv}, 128'd1);
        check("lit_tready_bubble", {127'd0, bus.tready}, 128'd0);
        check("lit_cmd1", command, 128'h000102030405060708090A0B0C0D0E0F);
        idle(2);
        check("lit_fcnt1", {112'd0, fcnt}, 128'd1);

        send_frame(8'hA0, 5, 0);
        check("lit_short_err", {127'd0, ferr}, 128'd1);
        idle(2);
        check("lit_short_code", {126'd0, code}, 128'd1);
        check("lit_short_ecnt", {112'd0, ecnt}, 128'd1);
        check("lit_short_cmd_hold", command, 128'h000102030405060708090A0B0C0D0E0F);
        send_frame(8'h10, 16, 0);
        idle(1);
        check("lit_cmd2", command, 128'h101112131415161718191A1B1C1D1E1F);

        send_frame(8'h40, 20, 0);
        check("lit_long_err", {127'd0, ferr}, 128'd1);
        idle(2);
        check("lit_long_code", {126'd0, code}, 128'd2);
        check("lit_long_ecnt", {112'd0, ecnt}, 128'd2);
        send_frame(8'h20, 16, 0);
        idle(1);
        check("lit_cmd3", command, 128'h202122232425262728292A2B2C2D2E2F);
        check("lit_code_kept", {126'd0, code}, 128'd2);

        send_frame(8'h30, 16, 50);
        idle(1);
        check("lit_cmd_gaps", command, 128'h303132333435363738393A3B3C3D3E3F);
        for (int i = 0; i < 7; i++) send(8'h50 + 8'(i), 1'b0, 50);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("lit_rst_mid_fcnt", {112'd0, fcnt}, 128'd0);
        // The tail of the interrupted frame is seen as a fresh, short frame.
        for (int i = 7; i < 16; i++) send(8'h50 + 8'(i), i == 15, 0);
        idle(2);
        check("lit_tail_code", {126'd0, code}, 128'd1);
        check("lit_tail_ecnt", {112'd0, ecnt}, 128'd1);
        send_frame(8'h60, 16, 0);
        idle(1);
        check("lit_cmd_clean", command, 128'h606162636465666768696A6B6C6D6E6F);
        check("lit_fcnt_clean", {112'd0, fcnt}, 128'd1);

`ifdef TSS_RX_TIMEOUT_EN
        send_frame(8'h70, 3, 0);
        idle(TIMEOUT);
        check("lit_to_err", {127'd0, ferr}, 128'd1);
        idle(2);
        check("lit_to_code", {126'd0, code}, 128'd3);
        for (int i = 0; i < 3; i++) send(8'h80 + 8'(i), 1'b0, 0);
        idle(TIMEOUT - 1);
        for (int i = 3; i < 16; i++) send(8'h80 + 8'(i), i == 15, 0);
        idle(1);
        check("lit_to_edge_cmd", command, 128'h808182838485868788898A8B8C8D8E8F);
        check("lit_to_edge_code", {126'd0, code}, 128'd3);
`else
        for (int i = 0; i < 3; i++) send(8'h90 + 8'(i), 1'b0, 0);
        idle(TIMEOUT + 76);
        for (int i = 3; i < 16; i++) send(8'h90 + 8'(i), i == 15, 0);
        idle(1);
        check("lit_stall_cmd", command, 128'h909192939495969798999A9B9C9D9E9F);
`endif

        for (int f = 0; f < 3; f++) send_frame(8'hB0 + 8'(f), 16, 0);
        for (int f = 0; f < 3; f++) send_frame(8'hC0, 2, 0);
        idle(2);
        check("lit_fcnt_sat", {126'd0, fcnt2}, 128'd3);
        check("lit_ecnt_sat", {126'd0, ecnt2}, 128'd3);
        send_frame(8'hD0, 16, 0);
        idle(2);
        check("lit_fcnt_sat_hold", {126'd0, fcnt2}, 128'd3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tss_deserializer_rx.md
Name: tss_deserializer_rx

Overview:
- Receive-side counterpart of the TSS transmit serializer. Consumes the byte-wide AXI-Stream that carries timestamp-sync commands and rebuilds each COMMAND_WIDTH-bit command word.
- Presents each rebuilt command to the receive-side controller as a registered word with a one-cycle valid strobe.
- Checks every frame's length against the expected byte count. Drops malformed frames and reports them through an error strobe, a held error code and saturating statistics counters.

Parameters:
- COMMAND_WIDTH, 128, command word width in bits. Must be a multiple of 8 and at least 16. N = COMMAND_WIDTH/8 bytes per frame.
- CNT_WIDTH, 16, width of the frame and error statistics counters.
- TIMEOUT_CYCLES, 1024, idle-gap limit inside a frame. Used only with TSS_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- s_axis_tdata  in  8  command byte, most-significant byte first
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when tvalid && tready
- s_axis_tlast  in  1  last byte of frame
- command_o  out  COMMAND_WIDTH  last good command
- command_valid_o  out  1  one-cycle strobe: command_o updated
- frame_err_o  out  1  one-cycle strobe: frame dropped
- err_code_o  out  2  cause of most recent error: 00 none, 01 short, 10 long, 11 timeout
- frame_cnt_o  out  CNT_WIDTH  good frames, saturating
- err_cnt_o  out  CNT_WIDTH  dropped frames, saturating

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0 and the FSM goes to COLLECT with idx=0.
  - Any partial frame is discarded silently: no error strobe, no counter change.
  - A frame still in flight when rst_n rises is not realigned. Its tail bytes are treated as a new frame.
- A beat is a cycle with s_axis_tvalid && s_axis_tready. Nothing changes on a non-beat cycle, apart from the timeout counter (Optional Feature).
- The shift register is shadow storage. command_o is loaded only on a good frame and holds its value otherwise.
- FSM states: COLLECT, DROP, DONE.
- COLLECT (s_axis_tready=1). On each beat, the byte is shifted into the shadow register (first byte lands in bits [W-1:W-8]) and idx increments. Per beat:
  - tlast && idx==N-1: good frame, go to DONE.
  - tlast && idx<N-1: short frame. frame_err_o=1 next cycle, err_code_o=01, err_cnt_o++, idx=0, stay in COLLECT.
  - !tlast && idx==N-1: long frame, go to DROP.
  - otherwise: stay in COLLECT.
- DROP (s_axis_tready=1):
  - Beats are discarded.
  - A beat with tlast gives frame_err_o=1 next cycle, err_code_o=10, err_cnt_o++, idx=0, go to COLLECT.
- DONE (lasts exactly 1 cycle; s_axis_tready=0):
  - command_o <= shadow, command_valid_o=1, frame_cnt_o++.
  - Next state COLLECT with idx=0.
- Latency:
  - command_valid_o is high in the cycle immediately after the tlast beat.
  - Throughput is one frame per N+1 cycles; the one-cycle bubble is the DONE state.
- Strobes: command_valid_o and frame_err_o are registered, each lasting exactly one cycle, and are never high together.
- err_code_o holds its value until the next error. It is never cleared by a good frame.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- s_axis_tready is a registered function of state only; it never depends combinationally on tvalid.
- N=... 1-byte frames are not supported (COMMAND_WIDTH>=16).

Optional Feature:
- Macro: TSS_RX_TIMEOUT_EN.
- Defined:
  - A gap counter clears on every beat and counts cycles with no beat while in COLLECT with idx>0, or in DROP.
  - When the count reaches TIMEOUT_CYCLES: frame_err_o=1 next cycle, err_code_o=11, err_cnt_o++, idx=0, state COLLECT.
  - A beat arriving in the same cycle that the count reaches TIMEOUT_CYCLES wins, and no timeout is raised.
- Undefined: no gap counter is built, TIMEOUT_CYCLES is ignored, err_code_o never takes 11, and a frame may stall indefinitely.

Test Plan (COMMAND_WIDTH=128, N=16, TIMEOUT_CYCLES=1024):
- Reset, then a 16-byte frame 0x00..0x0F with tlast on 0x0F and tvalid held high -> command_o=0x000102...0F, command_valid_o pulses one cycle after the last beat, tready is low for exactly that cycle, frame_cnt_o=1.
- 5-byte frame with tlast on byte 5 -> frame_err_o pulse, err_code_o=01, err_cnt_o=1, command_o unchanged; a following good 16-byte frame is accepted correctly.
- 20-byte frame with tlast on byte 20 -> no command_valid_o; frame_err_o pulses after beat 20, err_code_o=10; the next good frame decodes correctly.
- Random tvalid gaps (about 50% duty) on a good frame, then rst_n low for 1 cycle after byte 7 of a second frame, followed by a clean frame -> first command correct; the reset frame produces no strobe and no counter change; the clean frame decodes.
- With TSS_RX_TIMEOUT_EN: 3 bytes, then 1024 idle cycles -> frame_err_o pulses, err_code_o=11. Separately, a beat exactly on the 1024th idle cycle -> no timeout. Without the macro: the same stall followed by the remaining 13 bytes -> a good command.
- Force frame_cnt_o to 0xFFFE, then send 3 good frames -> frame_cnt_o reads 0xFFFF and stays there.
